control_fsm: RTL and testbench
==============================

# control_fsm

Parametrised instruction-sequencing control unit for the small accumulator-less processor datapath. It owns its own step state machine and fetches instruction words with a valid/ack handshake. It drives the operand multiplexer, register-file write enables, ALU operand/result registers, immediate and PC write strobes for a configurable register count. Compared with the fixed four-step sequencer, it adds variable-length instructions (non-ALU ops take two cycles), a real HALTED state with resume, and fetch stalling.

## Interface
- NUM_REGS, 8, number of addressable registers; power of two, 4..64
- REG_SEL_W, $clog2(NUM_REGS), register field width (derived, not overridden)
- IW, 3+2*REG_SEL_W, instruction width: opcode[IW-1:IW-3], rx, ry (ry in LSBs)
- MUX_W, REG_SEL_W+1, mux_select width

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  reset, asynchronous, active-low
- instr_valid  in  1  iin holds a valid instruction word
- iin  in  IW  instruction word
- resume  in  1  leave HALTED
- instr_ack  out  1  instruction accepted this cycle
- mux_select  out  MUX_W  0..NUM_REGS-1 = register rx/ry, NUM_REGS = immediate, NUM_REGS+1 = ALU out, all-ones = no output
- regs_enable  out  NUM_REGS  one-hot register write enable
- alu_op_select  out  2  ALU operation (ADD 00, SUB 01, NAND 10, none 11)
- a_reg_enable  out  1  load ALU operand-A register
- alu_reg_enable  out  1  load ALU result register
- imm_wr_enable  out  1  load immediate register
- pc_wr_enable  out  1  PC update strobe
- branch_select  out  1  PC takes branch path (BEZ)
- halted  out  1  FSM in HALTED

## Operation
- Opcodes: ADD 000, SUB 001, NAND 010, HLT 011, OUT 100, LDI 101, BEZ 110, REP 111.
- States: FETCH, OPA, OPB, WB, HALT.
- FETCH: mux_select all-ones. If instr_valid, then instr_ack=1 and imm_wr_enable=1, iin is latched into the instruction register, and next state is HALT (HLT), OPA (ADD/SUB/NAND), or WB (all others). If instr_valid=0, stay in FETCH with all strobes 0.
- OPA: mux_select=rx, a_reg_enable=1, next state OPB.
- OPB: mux_select=ry, alu_reg_enable=1, next state WB.
- WB: pc_wr_enable=1, next state FETCH.
  - mux_select: OUT/BEZ → rx; REP → ry; LDI → NUM_REGS; ALU ops → NUM_REGS+1.
  - regs_enable=onehot(rx), except OUT and BEZ, which give 0.
  - branch_select=1 only for BEZ.
- HALT: halted=1, all strobes 0, mux all-ones. resume=1 moves to FETCH. instr_valid is ignored.
- alu_op_select = opcode[1:0] in OPA/OPB/WB for ALU ops, otherwise 11.
- Outputs decode combinationally from state and the latched instruction. The exception is FETCH strobes, which also depend on instr_valid.

## Timing
- Reset (async) puts the FSM in FETCH and clears the instruction register to 0. During and after reset every strobe is 0, mux_select is all-ones, alu_op_select=11, and halted=0.
- Latency from accept to WB strobe: ALU ops 3 cycles, for 4 cycles total including FETCH. LDI/OUT/BEZ/REP take 2 cycles total. After HLT, halted=1 on the next cycle.
- Back-to-back instructions: the next FETCH immediately follows WB. instr_valid held high gives 1 accept per 2 or 4 cycles.
- instr_valid outside FETCH is ignored and produces no ack. resume outside HALT is ignored. resume and instr_valid arriving together in HALT: only resume acts; the instruction is fetched the following cycle.
- resetn asserted mid-instruction drops all strobes asynchronously and the instruction is abandoned.

## Structure
- Shared package ctrl_pkg holds:
  - opcode localparams;
  - the state enum (FETCH=0, OPA=1, OPB=2, WB=3, HALT=4; 3-bit);
  - the ALU_NONE=2'b11 constant;
  - functions giving the IMM and ALU mux codes from NUM_REGS.
- Sub-module reg_onehot_decoder #(NUM_REGS): binary rx → one-hot, used for regs_enable.

## Test plan
- Reset: resetn=0 mid-OPB → same cycle, all strobes 0, mux_select=4'hF, halted=0. After release, state is FETCH.
- ADD r3,r5 (iin=9'b000_011_101, valid) → the cycles run as follows:
  - cycle 0: ack=1, imm_wr=1;
  - cycle 1: mux=3, a_reg=1, alu_op=00;
  - cycle 2: mux=5, alu_reg=1;
  - cycle 3: mux=9, regs_enable=8'h08, pc_wr=1;
  - cycle 4: back in FETCH.
- LDI r2 (9'b101_010_000) then REP r1,r7 (9'b111_001_111), valid held → LDI WB gives mux=8, regs_enable=8'h04. REP WB gives mux=7, regs_enable=8'h02. Acks land on cycles 0 and 2.
- BEZ r6 (9'b110_110_000) and OUT r4 (9'b100_100_000) → WB gives branch_select=1 only for BEZ, mux=6 / 4, regs_enable=0, pc_wr=1.
- HLT with instr_valid held → halted=1 from the next cycle with no acks. A resume pulse gives FETCH next cycle and an ack the cycle after.
- NUM_REGS=16, SUB r12,r0 (11'b001_1100_0000) → mux 12, then 0, then 17. regs_enable=16'h1000. Holding instr_valid low stalls FETCH indefinitely with no strobes.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction-sequencing control unit:
// opcodes, step-state encoding and mux-code helpers.
package ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_HLT  = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_BEZ  = 3'b110;
  localparam logic [2:0] OP_REP  = 3'b111;

  localparam logic [1:0] ALU_NONE = 2'b11;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    OPA   = 3'd1,
    OPB   = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } state_t;

  // Mux codes just above the register range select the immediate and ALU result.
  function automatic int unsigned imm_mux_code(int unsigned num_regs);
    return num_regs;
  endfunction

  function automatic int unsigned alu_mux_code(int unsigned num_regs);
    return num_regs + 1;
  endfunction

endpackage

// File: rtl/reg_onehot_decoder.sv
// Binary register index to one-hot write enable, gated by a global enable.
module reg_onehot_decoder #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                enable,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (enable) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_fsm.sv
// Instruction-sequencing control unit: fetches with a valid/ack handshake and
// steps the datapath through operand, ALU and write-back strobes.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REGS  = 8,
  localparam int unsigned REG_SEL_W = $clog2(NUM_REGS),
  localparam int unsigned IW        = 3 + 2 * REG_SEL_W,
  localparam int unsigned MUX_W     = REG_SEL_W + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                instr_valid,
  input  logic [IW-1:0]       iin,
  input  logic                resume,
  output logic                instr_ack,
  output logic [MUX_W-1:0]    mux_select,
  output logic [NUM_REGS-1:0] regs_enable,
  output logic [1:0]          alu_op_select,
  output logic                a_reg_enable,
  output logic                alu_reg_enable,
  output logic                imm_wr_enable,
  output logic                pc_wr_enable,
  output logic                branch_select,
  output logic                halted
);

  localparam logic [MUX_W-1:0] MUX_NONE = '1;
  localparam logic [MUX_W-1:0] MUX_IMM  = MUX_W'(imm_mux_code(NUM_REGS));
  localparam logic [MUX_W-1:0] MUX_ALU  = MUX_W'(alu_mux_code(NUM_REGS));

  state_t               state_q;
  state_t               state_d;
  logic [IW-1:0]        ir_q;
  logic                 ir_load;
  logic                 reg_we;
  logic [2:0]           opcode;
  logic [2:0]           iin_op;
  logic [REG_SEL_W-1:0] rx;
  logic [REG_SEL_W-1:0] ry;
  logic                 is_alu;
  logic                 iin_is_alu;

  assign opcode     = ir_q[IW-1 -: 3];
  assign rx         = ir_q[2*REG_SEL_W-1 -: REG_SEL_W];
  assign ry         = ir_q[REG_SEL_W-1:0];
  assign iin_op     = iin[IW-1 -: 3];
  assign is_alu     = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_NAND);
  assign iin_is_alu = (iin_op == OP_ADD) || (iin_op == OP_SUB) || (iin_op == OP_NAND);

  // State and instruction register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= iin;
    end
  end

  // Next-state and strobe decode from state plus latched instruction.
  always_comb begin
    state_d        = state_q;
    ir_load        = 1'b0;
    reg_we         = 1'b0;
    instr_ack      = 1'b0;
    mux_select     = MUX_NONE;
    alu_op_select  = ALU_NONE;
    a_reg_enable   = 1'b0;
    alu_reg_enable = 1'b0;
    imm_wr_enable  = 1'b0;
    pc_wr_enable   = 1'b0;
    branch_select  = 1'b0;
    halted         = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (instr_valid) begin
          instr_ack     = 1'b1;
          imm_wr_enable = 1'b1;
          ir_load       = 1'b1;
          if (iin_op == OP_HLT) state_d = HALT;
          else if (iin_is_alu)  state_d = OPA;
          else                  state_d = WB;
        end
      end
      OPA: begin
        mux_select    = MUX_W'(rx);
        a_reg_enable  = 1'b1;
        alu_op_select = is_alu ? opcode[1:0] : ALU_NONE;
        state_d       = OPB;
      end
      OPB: begin
        mux_select     = MUX_W'(ry);
        alu_reg_enable = 1'b1;
        alu_op_select  = is_alu ? opcode[1:0] : ALU_NONE;
        state_d        = WB;
      end
      WB: begin
        pc_wr_enable  = 1'b1;
        alu_op_select = is_alu ? opcode[1:0] : ALU_NONE;
        branch_select = (opcode == OP_BEZ);
        reg_we        = (opcode != OP_OUT) && (opcode != OP_BEZ);
        case (opcode)
          OP_OUT, OP_BEZ: mux_select = MUX_W'(rx);
          OP_REP:         mux_select = MUX_W'(ry);
          OP_LDI:         mux_select = MUX_IMM;
          default:        mux_select = MUX_ALU;
        endcase
        state_d = FETCH;
      end
      HALT: begin
        halted = 1'b1;
        if (resume) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  reg_onehot_decoder #(
    .NUM_REGS(NUM_REGS),
    .SEL_W   (REG_SEL_W)
  ) u_regs_dec (
    .sel   (rx),
    .enable(reg_we),
    .onehot(regs_enable)
  );

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: 8- and 16-register instances run in
// lockstep against an instruction-level expectation model plus literal checks.
module tb_control_fsm;

  typedef struct packed {
    logic        ack;
    logic [4:0]  mux;
    logic [15:0] regs;
    logic [1:0]  alu;
    logic        a;
    logic        ar;
    logic        imm;
    logic        pc;
    logic        br;
    logic        hlt;
  } rec_t;

  logic clk = 1'b0;
  logic resetn;
  logic valid;
  logic resume;
  int   op, rx, ry;
  int   errors = 0;
  int   checks = 0;

  logic [8:0]  iin8;
  logic [10:0] iin16;
  assign iin8  = {3'(op), 3'(rx), 3'(ry)};
  assign iin16 = {3'(op), 4'(rx), 4'(ry)};

  logic        ack8, a8, ar8, imm8, pc8, br8, hlt8;
  logic [3:0]  mux8;
  logic [7:0]  regs8;
  logic [1:0]  alu8;
  logic        ack16, a16, ar16, imm16, pc16, br16, hlt16;
  logic [4:0]  mux16;
  logic [15:0] regs16;
  logic [1:0]  alu16;

  always #5 clk = ~clk;

  control_fsm #(.NUM_REGS(8)) dut8 (
    .clk(clk), .resetn(resetn), .instr_valid(valid), .iin(iin8), .resume(resume),
    .instr_ack(ack8), .mux_select(mux8), .regs_enable(regs8), .alu_op_select(alu8),
    .a_reg_enable(a8), .alu_reg_enable(ar8), .imm_wr_enable(imm8),
    .pc_wr_enable(pc8), .branch_select(br8), .halted(hlt8)
  );

  control_fsm #(.NUM_REGS(16)) dut16 (
    .clk(clk), .resetn(resetn), .instr_valid(valid), .iin(iin16), .resume(resume),
    .instr_ack(ack16), .mux_select(mux16), .regs_enable(regs16), .alu_op_select(alu16),
    .a_reg_enable(a16), .alu_reg_enable(ar16), .imm_wr_enable(imm16),
    .pc_wr_enable(pc16), .branch_select(br16), .halted(hlt16)
  );

  rec_t act8, act16;
  assign act8  = {ack8, 5'(mux8), 16'(regs8), alu8, a8, ar8, imm8, pc8, br8, hlt8};
  assign act16 = {ack16, mux16, regs16, alu16, a16, ar16, imm16, pc16, br16, hlt16};

  function automatic rec_t idle_rec(int nr);
    rec_t r;
    r     = '0;
    r.alu = 2'b11;
    r.mux = 5'(2 * nr - 1);
    return r;
  endfunction

  // Outputs expected k cycles after an instruction is accepted (k=0 is the fetch).
  function automatic rec_t step_rec(int nr, int o, int x, int y, int k);
    rec_t r;
    bit   alu;
    r   = idle_rec(nr);
    alu = (o < 3);
    if (k == 0) begin
      r.ack = 1'b1;
      r.imm = 1'b1;
    end else if (alu && k == 1) begin
      r.mux = 5'(x);
      r.a   = 1'b1;
      r.alu = 2'(o);
    end else if (alu && k == 2) begin
      r.mux = 5'(y);
      r.ar  = 1'b1;
      r.alu = 2'(o);
    end else begin
      r.pc  = 1'b1;
      r.alu = alu ? 2'(o) : 2'b11;
      r.br  = (o == 6);
      case (o)
        4, 6:    r.mux = 5'(x);
        7:       r.mux = 5'(y);
        5:       r.mux = 5'(nr);
        default: r.mux = 5'(nr + 1);
      endcase
      r.regs = (o == 4 || o == 6) ? 16'h0 : (16'h1 << x);
    end
    return r;
  endfunction

  int m_busy[2], m_k[2], m_op[2], m_rx[2], m_ry[2], m_halt[2];

  // Instruction-level model, compared against both instances every cycle.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int   nr;
      rec_t e;
      rec_t got;
      nr  = (u == 0) ? 8 : 16;
      got = (u == 0) ? act8 : act16;
      if (resetn !== 1'b1) begin
        e         = idle_rec(nr);
        m_busy[u] = 0;
        m_halt[u] = 0;
      end else if (m_busy[u] != 0) begin
        e = step_rec(nr, m_op[u], m_rx[u], m_ry[u], m_k[u]);
        m_k[u]++;
        if (m_k[u] == ((m_op[u] < 3) ? 4 : 2)) m_busy[u] = 0;
      end else if (m_halt[u] != 0) begin
        e     = idle_rec(nr);
        e.hlt = 1'b1;
        if (resume) m_halt[u] = 0;
      end else if (valid) begin
        m_op[u] = op & 7;
        m_rx[u] = rx & (nr - 1);
        m_ry[u] = ry & (nr - 1);
        e       = step_rec(nr, 0, 0, 0, 0);
        if (m_op[u] == 3) m_halt[u] = 1;
        else begin
          m_busy[u] = 1;
          m_k[u]    = 1;
        end
      end else begin
        e = idle_rec(nr);
      end
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL model_n%0d t=%0t got=%h expected=%h", nr, $time, got, e);
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  int vop[8] = '{0, 1, 2, 4, 5, 6, 7, 2};
  int vrx[8] = '{7, 9, 0, 15, 1, 3, 11, 6};
  int vry[8] = '{2, 14, 5, 0, 6, 8, 13, 7};

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; valid = 1'b0; resume = 1'b0; op = 0; rx = 0; ry = 0;
    sample();
    chk("rst_mux", int'(mux8), 15);
    chk("rst_alu", int'(alu8), 3);
    chk("rst_halted", int'(hlt8), 0);
    tick(); resetn = 1'b1;

    // ADD r3,r5
    tick(); valid = 1'b1; op = 0; rx = 3; ry = 5;
    sample(); chk("add_c0_ack", ack8, 1); chk("add_c0_imm", imm8, 1);
    tick(); valid = 1'b0;
    sample(); chk("add_c1_mux", mux8, 3); chk("add_c1_a", a8, 1); chk("add_c1_alu", alu8, 0);
    tick(); sample(); chk("add_c2_mux", mux8, 5); chk("add_c2_ar", ar8, 1);
    tick(); sample(); chk("add_c3_mux", mux8, 9); chk("add_c3_regs", regs8, 8); chk("add_c3_pc", pc8, 1);
    tick(); sample(); chk("add_c4_mux", mux8, 15);

    // LDI r2 then REP r1,r7, valid held
    tick(); valid = 1'b1; op = 5; rx = 2; ry = 0;
    sample(); chk("ldi_ack", ack8, 1);
    tick(); op = 7; rx = 1; ry = 7;
    sample(); chk("ldi_wb_ack", ack8, 0); chk("ldi_wb_mux", mux8, 8); chk("ldi_wb_regs", regs8, 4);
    tick(); sample(); chk("rep_ack", ack8, 1);
    tick(); valid = 1'b0;
    sample(); chk("rep_wb_mux", mux8, 7); chk("rep_wb_regs", regs8, 2);

    // BEZ r6 then OUT r4
    tick(); valid = 1'b1; op = 6; rx = 6; ry = 0;
    sample(); chk("bez_ack", ack8, 1);
    tick(); op = 4; rx = 4;
    sample(); chk("bez_br", br8, 1); chk("bez_mux", mux8, 6); chk("bez_regs", regs8, 0); chk("bez_pc", pc8, 1);
    tick(); sample(); chk("out_ack", ack8, 1);
    tick(); valid = 1'b0;
    sample(); chk("out_br", br8, 0); chk("out_mux", mux8, 4); chk("out_regs", regs8, 0); chk("out_pc", pc8, 1);

    // HLT with valid held, then resume
    tick(); valid = 1'b1; op = 3; rx = 0; ry = 0;
    sample(); chk("hlt_ack", ack8, 1); chk("hlt_c0_halted", hlt8, 0);
    tick(); op = 0; rx = 1; ry = 2;
    sample(); chk("hlt_c1_halted", hlt8, 1); chk("hlt_c1_ack", ack8, 0);
    tick(); sample(); chk("hlt_c2_halted", hlt8, 1); chk("hlt_c2_ack", ack8, 0);
    tick(); resume = 1'b1;
    sample(); chk("res_c0_halted", hlt8, 1); chk("res_c0_ack", ack8, 0);
    tick(); resume = 1'b0;
    sample(); chk("res_c1_halted", hlt8, 0); chk("res_c1_ack", ack8, 1);
    tick(); valid = 1'b0;
    repeat (2) tick();

    // Reset asserted in OPB of a NAND
    tick(); valid = 1'b1; op = 2; rx = 5; ry = 6;
    sample(); chk("nand_ack", ack8, 1);
    tick(); valid = 1'b0;
    sample(); chk("nand_a", a8, 1); chk("nand_alu", alu8, 2);
    tick(); resetn = 1'b0;
    #1;
    chk("rstmid_ar", ar8, 0); chk("rstmid_mux", mux8, 15);
    chk("rstmid_halted", hlt8, 0); chk("rstmid_alu", alu8, 3);
    sample();
    tick(); resetn = 1'b1;
    sample(); chk("rstrel_mux", mux8, 15); chk("rstrel_ack", ack8, 0);

    // SUB r12,r0 on the 16-register instance, then a stalled fetch
    tick(); valid = 1'b1; op = 1; rx = 12; ry = 0;
    sample(); chk("sub16_ack", ack16, 1);
    tick(); valid = 1'b0;
    sample(); chk("sub16_c1_mux", mux16, 12); chk("sub16_c1_alu", alu16, 1);
    tick(); sample(); chk("sub16_c2_mux", mux16, 0);
    tick(); sample(); chk("sub16_c3_mux", mux16, 17); chk("sub16_c3_regs", regs16, 'h1000);
    repeat (6) begin
      tick(); sample(); chk("stall_ack", ack16, 0); chk("stall_imm", imm16, 0);
    end

    // Vector table, with resume pulses outside HALT
    for (int i = 0; i < 8; i++) begin
      bit got;
      tick(); valid = 1'b1; op = vop[i]; rx = vrx[i]; ry = vry[i]; resume = 1'(i % 2);
      got = 1'b0;
      for (int c = 0; c < 8; c++) begin
        sample();
        if (ack8) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      chk("vec_ack_wait", got, 1);
      tick(); valid = 1'b0; resume = 1'b0;
      repeat (3) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
